// File: rtl/slice_sum_accumulator.sv
// slice_sum_accumulator: sums blocks of NACC unsigned samples from the bit-slice
// adder stage into a widened total. Each closed block is offered downstream
// as SUM/LEN/OVF on a valid/ready handshake. FLUSH closes a partial block early.
module slice_sum_accumulator #(
    parameter int unsigned NIN  = 4,
    parameter int unsigned NACC = 8,
    parameter int unsigned NOUT = 7,
    parameter int unsigned NLEN = $clog2(NACC + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NIN-1:0]  XIN,
    input  logic            XIN_VALID,
    output logic            XIN_READY,
    input  logic            FLUSH,
    output logic [NOUT-1:0] SUM,
    output logic [NLEN-1:0] LEN,
    output logic            OVF,
    output logic            SUM_VALID,
    input  logic            SUM_READY
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [NOUT-1:0] acc;
    logic [NLEN-1:0] cnt;
    logic            ovf_acc;

    logic            xfer;
    logic [NOUT:0]   nsum;
    logic [NOUT-1:0] nacc;
    logic            nwrap;
    logic [NLEN-1:0] ncnt;
    logic            close;

    // Ready depends only on state and reset, never on the incoming sample
    assign XIN_READY = (state == ACC) && !RST;
    assign xfer      = XIN_VALID && XIN_READY;

    // Next accumulator value, carry-out and count including this cycle's sample
    always_comb begin
        nsum = {1'b0, acc};
        if (xfer) begin
            nsum = {1'b0, acc} + {1'b0, NOUT'(XIN)};
        end
        nacc  = nsum[NOUT-1:0];
        nwrap = nsum[NOUT];
        ncnt  = cnt + NLEN'(xfer);
        close = (ncnt == NLEN'(NACC)) || (FLUSH && (ncnt != '0));
    end

    // Accumulate in ACC, present and hold the block result in HOLD
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            SUM       <= '0;
            LEN       <= '0;
            OVF       <= 1'b0;
            SUM_VALID <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (close) begin
                        SUM       <= nacc;
                        LEN       <= ncnt;
                        OVF       <= ovf_acc | nwrap;
                        SUM_VALID <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf_acc   <= 1'b0;
                        state     <= HOLD;
                    end else begin
                        acc     <= nacc;
                        cnt     <= ncnt;
                        ovf_acc <= ovf_acc | nwrap;
                    end
                end
                HOLD: begin
                    if (SUM_READY) begin
                        SUM_VALID <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_sum_accumulator.sv
// tb_slice_sum_accumulator: directed checks of the block accumulator, a
// per-cycle vector table plus hand-written multi-cycle sequences. A second
// instance with NOUT=5 shares the stimulus and covers the wrap/overflow case.
module tb_slice_sum_accumulator;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] XIN = '0;
    logic       XIN_VALID = 1'b0;
    logic       FLUSH = 1'b0;
    logic       SUM_READY = 1'b0;

    logic       xrdy7, ovf7, sv7;
    logic [6:0] sum7;
    logic [3:0] len7;
    logic       xrdy5, ovf5, sv5;
    logic [4:0] sum5;
    logic [3:0] len5;

    int tests = 0;
    int fails = 0;

    slice_sum_accumulator #(.NIN(4), .NACC(8), .NOUT(7)) dut7 (
        .CLK(CLK), .RST(RST), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(xrdy7),
        .FLUSH(FLUSH), .SUM(sum7), .LEN(len7), .OVF(ovf7), .SUM_VALID(sv7),
        .SUM_READY(SUM_READY)
    );

    slice_sum_accumulator #(.NIN(4), .NACC(8), .NOUT(5)) dut5 (
        .CLK(CLK), .RST(RST), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(xrdy5),
        .FLUSH(FLUSH), .SUM(sum5), .LEN(len5), .OVF(ovf5), .SUM_VALID(sv5),
        .SUM_READY(SUM_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] xin;
        logic       valid;
        logic       flush;
        logic       sready;
        logic       xrdy;
        logic       sv;
        logic       chkd;
        logic [6:0] sum;
        logic [3:0] len;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic r, input logic [3:0] x, input logic v,
                       input logic f, input logic s, input logic er, input logic esv,
                       input logic ec, input logic [6:0] es, input logic [3:0] el,
                       input logic eo);
        vec_t t;
        t.name = n; t.rst = r; t.xin = x; t.valid = v; t.flush = f; t.sready = s;
        t.xrdy = er; t.sv = esv; t.chkd = ec; t.sum = es; t.len = el; t.ovf = eo;
        vq.push_back(t);
    endtask

    task automatic chk(input string n, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic cyc(input logic r, input logic [3:0] x, input logic v,
                       input logic f, input logic s);
        RST = r; XIN = x; XIN_VALID = v; FLUSH = f; SUM_READY = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic res7(input string n, input int esv, input int es, input int el,
                        input int eo);
        chk({n, "_valid"}, int'(sv7), esv);
        chk({n, "_sum"}, int'(sum7), es);
        chk({n, "_len"}, int'(len7), el);
        chk({n, "_ovf"}, int'(ovf7), eo);
    endtask

    initial begin
        // reset, full block of 15s with one-cycle bubble, flush cases
        add("rst", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k < 8; k++) add("full", 0, 15, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add("full_close", 0, 15, 1, 0, 1, 0, 1, 1, 120, 8, 0);
        add("full_bubble", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add("fl_s1", 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add("fl_s2", 0, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add("fl_s3", 0, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add("fl_close", 0, 4, 1, 1, 1, 0, 1, 1, 10, 4, 0);
        add("fl_accept", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add("fl_empty", 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add("fl_empty2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add("fl_one", 0, 5, 1, 1, 0, 0, 1, 1, 5, 1, 0);
        add("hold_flush", 0, 6, 1, 1, 0, 0, 1, 1, 5, 1, 0);
        add("hold_accept", 0, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].xin, vq[i].valid, vq[i].flush, vq[i].sready);
            chk({vq[i].name, "_xrdy"}, int'(xrdy7), int'(vq[i].xrdy));
            chk({vq[i].name, "_valid"}, int'(sv7), int'(vq[i].sv));
            if (vq[i].chkd) begin
                chk({vq[i].name, "_sum"}, int'(sum7), int'(vq[i].sum));
                chk({vq[i].name, "_len"}, int'(len7), int'(vq[i].len));
                chk({vq[i].name, "_ovf"}, int'(ovf7), int'(vq[i].ovf));
            end
        end

        // backpressure: 1..8 held while SUM_READY=0, pending sample 9 kept
        for (int k = 1; k <= 8; k++) cyc(0, 4'(k), 1, 0, 0);
        res7("bp_close", 1, 36, 8, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 9, 1, 0, 0);
            res7("bp_hold", 1, 36, 8, 0);
            chk("bp_hold_xrdy", int'(xrdy7), 0);
        end
        cyc(0, 9, 1, 0, 1);
        chk("bp_accept_valid", int'(sv7), 0);
        chk("bp_accept_xrdy", int'(xrdy7), 1);
        cyc(0, 9, 1, 0, 1);
        for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 1);
        res7("bp_next", 1, 16, 8, 0);
        cyc(0, 0, 0, 0, 1);
        chk("bp_next_accept", int'(sv7), 0);

        // overflow on the NOUT=5 instance, then a clean block
        for (int k = 0; k < 8; k++) cyc(0, 15, 1, 0, 1);
        chk("ovf5_valid", int'(sv5), 1);
        chk("ovf5_sum", int'(sum5), 24);
        chk("ovf5_len", int'(len5), 8);
        chk("ovf5_ovf", int'(ovf5), 1);
        res7("ovf7", 1, 120, 8, 0);
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0, 1);
        chk("ovf5b_valid", int'(sv5), 1);
        chk("ovf5b_sum", int'(sum5), 8);
        chk("ovf5b_len", int'(len5), 8);
        chk("ovf5b_ovf", int'(ovf5), 0);
        cyc(0, 0, 0, 0, 1);

        // reset mid-block discards partial sum
        for (int k = 0; k < 5; k++) cyc(0, 7, 1, 0, 1);
        cyc(1, 0, 0, 0, 1);
        res7("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_xrdy", int'(xrdy7), 0);
        for (int k = 0; k < 8; k++) cyc(0, 2, 1, 0, 1);
        res7("rst_after", 1, 16, 8, 0);
        cyc(0, 0, 0, 0, 1);

        // reset while holding a result drops it
        for (int k = 0; k < 8; k++) cyc(0, 2, 1, 0, 0);
        chk("rst_hold_pre", int'(sv7), 1);
        cyc(1, 0, 0, 0, 0);
        chk("rst_hold_valid", int'(sv7), 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_hold_after_valid", int'(sv7), 0);
        chk("rst_hold_after_xrdy", int'(xrdy7), 1);

        // gapped input: valid every other cycle, result one cycle after 8th transfer
        for (int i = 0; i < 15; i++) begin
            cyc(0, 3, (i % 2 == 0), 0, 1);
            chk($sformatf("gap_valid_%0d", i), int'(sv7), (i == 14) ? 1 : 0);
        end
        res7("gap_close", 1, 24, 8, 0);
        cyc(0, 0, 0, 0, 1);
        chk("gap_accept", int'(sv7), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
